// File: rtl/im2col_spc_regintfc_responder.sv
// Register-interface target for the im2col SPC: a bank of byte-strobed 32-bit registers
// answered with a programmable wait, exported to downstream accelerator logic.

package im2col_spc_regintfc_pkg;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } reg_req_t;

  typedef struct packed {
    logic        ready;
    logic        error;
    logic [31:0] rdata;
  } reg_rsp_t;

endpackage

module im2col_spc_regintfc_responder
  import im2col_spc_regintfc_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  reg_req_t                 reg_req_i,
  output reg_rsp_t                 reg_rsp_o,
  output logic [NUM_REGS*32-1:0]   regs_o,
  output logic [NUM_REGS-1:0]      wr_pulse_o,
  output logic                     busy_o
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   wr_q, wr_d;
  logic                   err_q, err_d;
  logic [3:0]             strb_q, strb_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [NUM_REGS*32-1:0] regs_q;

  reg_rsp_t               rsp_d;
  logic [NUM_REGS-1:0]    pulse_d;
  logic                   busy_d;
  logic                   apply_wr;
  logic                   req_err;
  logic [IDX_W-1:0]       req_idx;

  // Misaligned or beyond the last register
  assign req_err = (reg_req_i.addr[1:0] != 2'b00) || (reg_req_i.addr[31:2] >= 30'(NUM_REGS));
  assign req_idx = reg_req_i.addr[IDX_W+1:2];

  assign regs_o = regs_q;

  // Next state, latched request and response generation
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    err_d    = err_q;
    strb_d   = strb_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    rsp_d    = '0;
    pulse_d  = '0;
    apply_wr = 1'b0;
    busy_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (reg_req_i.valid) begin
          wr_d    = reg_req_i.write;
          err_d   = req_err;
          strb_d  = reg_req_i.wstrb;
          idx_d   = req_idx;
          wdata_d = reg_req_i.wdata;
          cnt_d   = CNT_LOAD;
          state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (wr_q && !err_q) begin
          apply_wr       = 1'b1;
          pulse_d[idx_q] = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Response is registered on entry to RESP; idx_d/err_d/wr_d hold the transaction there
    if (state_d == ST_RESP) begin
      rsp_d.ready = 1'b1;
      rsp_d.error = err_d;
      if (!wr_d && !err_d) begin
        rsp_d.rdata = regs_q[{idx_d, 5'd0} +: 32];
      end
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      strb_q     <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      regs_q     <= '0;
      reg_rsp_o  <= '0;
      wr_pulse_o <= '0;
      busy_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      err_q      <= err_d;
      strb_q     <= strb_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      reg_rsp_o  <= rsp_d;
      wr_pulse_o <= pulse_d;
      busy_o     <= busy_d;
      // Write lands at the edge closing RESP
      if (apply_wr) begin
        for (int b = 0; b < 4; b++) begin
          if (strb_q[b]) begin
            regs_q[{idx_q, 2'(b), 3'd0} +: 8] <= wdata_q[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_im2col_spc_regintfc_responder.sv
// Bench for im2col_spc_regintfc_responder: four instances (WAIT_CYCLES 1,0,3,15) share one
// request stream and are checked every cycle against a transaction-level model.

module tb_im2col_spc_regintfc_responder;
  import im2col_spc_regintfc_pkg::*;

  localparam int NI = 4;
  localparam int NR = 8;

  function automatic int wv(input int i);
    case (i)
      0:       return 1;
      1:       return 0;
      2:       return 3;
      default: return 15;
    endcase
  endfunction

  // Hand-computed figures: cycles from acceptance to ready, and ready-to-ready gap
  function automatic int lit_lat(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      2:       return 4;
      default: return 16;
    endcase
  endfunction

  function automatic int lit_gap(input int i);
    case (i)
      0:       return 3;
      1:       return 2;
      2:       return 5;
      default: return 17;
    endcase
  endfunction

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  reg_req_t req = '0;

  reg_rsp_t            rsp    [NI];
  logic [NR*32-1:0]    regs_v [NI];
  logic [NR-1:0]       pl     [NI];
  logic                busy_v [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    im2col_spc_regintfc_responder #(
      .NUM_REGS    (NR),
      .WAIT_CYCLES (wv(g))
    ) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .reg_req_i  (req),
      .reg_rsp_o  (rsp[g]),
      .regs_o     (regs_v[g]),
      .wr_pulse_o (pl[g]),
      .busy_o     (busy_v[g])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: each accepted request answers W edges later, completes one edge after
  int           edge_n = 0;
  bit           outst   [NI];
  int           t_acc   [NI];
  bit           t_wr    [NI];
  bit           t_err   [NI];
  logic [3:0]   t_strb  [NI];
  int           t_idx   [NI];
  logic [31:0]  t_wdata [NI];
  logic [31:0]  mregs   [NI][NR];
  logic         e_ready [NI];
  logic         e_err   [NI];
  logic [31:0]  e_rdata [NI];
  logic [NR-1:0] e_pulse[NI];
  logic         e_busy  [NI];

  always @(posedge clk) begin
    edge_n++;
    for (int i = 0; i < NI; i++) begin
      bit was_idle;
      e_ready[i] = 1'b0;
      e_err[i]   = 1'b0;
      e_rdata[i] = '0;
      e_pulse[i] = '0;
      if (rst) begin
        outst[i] = 1'b0;
        for (int k = 0; k < NR; k++) mregs[i][k] = '0;
      end else begin
        was_idle = !outst[i];
        if (outst[i] && edge_n == t_acc[i] + 1 + wv(i)) begin
          outst[i] = 1'b0;
          if (t_wr[i] && !t_err[i]) begin
            for (int b = 0; b < 4; b++)
              if (t_strb[i][b]) mregs[i][t_idx[i]][8*b +: 8] = t_wdata[i][8*b +: 8];
            e_pulse[i] = NR'(1) << t_idx[i];
          end
        end
        if (was_idle && req.valid) begin
          outst[i]   = 1'b1;
          t_acc[i]   = edge_n;
          t_wr[i]    = req.write;
          t_err[i]   = (req.addr % 4 != 0) || (req.addr / 4 >= NR);
          t_idx[i]   = t_err[i] ? 0 : int'(req.addr / 4);
          t_strb[i]  = req.wstrb;
          t_wdata[i] = req.wdata;
        end
        if (outst[i] && edge_n == t_acc[i] + wv(i)) begin
          e_ready[i] = 1'b1;
          e_err[i]   = t_err[i];
          e_rdata[i] = (!t_wr[i] && !t_err[i]) ? mregs[i][t_idx[i]] : 32'h0;
        end
      end
      e_busy[i] = outst[i];
    end
  end

  typedef struct { int e; logic err; logic [31:0] rd; } rsp_rec_t;
  typedef struct { int e; logic [NR-1:0] v; } pl_rec_t;
  rsp_rec_t rq [NI][$];
  pl_rec_t  pq [NI][$];

  // Every-cycle compare against the model, plus a log of responses and pulses
  always @(negedge clk) begin : cmp
    logic [NR*32-1:0] flat;
    if (edge_n >= 1) begin
      for (int i = 0; i < NI; i++) begin
        for (int k = 0; k < NR; k++) flat[32*k +: 32] = mregs[i][k];
        check($sformatf("w%0d_ready", wv(i)), rsp[i].ready, e_ready[i]);
        check($sformatf("w%0d_error", wv(i)), rsp[i].error, e_err[i]);
        check($sformatf("w%0d_rdata", wv(i)), rsp[i].rdata, e_rdata[i]);
        check($sformatf("w%0d_pulse", wv(i)), pl[i], e_pulse[i]);
        check($sformatf("w%0d_busy", wv(i)), busy_v[i], e_busy[i]);
        check($sformatf("w%0d_regs", wv(i)), regs_v[i], flat);
        if (rsp[i].ready === 1'b1) rq[i].push_back('{edge_n, rsp[i].error, rsp[i].rdata});
        if (pl[i] !== '0) pq[i].push_back('{edge_n, pl[i]});
      end
    end
  end

  int bq [NI];
  int bp [NI];

  task automatic snap();
    for (int i = 0; i < NI; i++) begin
      bq[i] = rq[i].size();
      bp[i] = pq[i].size();
    end
  endtask

  // One request held for exactly its acceptance edge, then let every instance drain
  task automatic txn(input bit wr, input logic [3:0] st, input logic [31:0] a,
                     input logic [31:0] wd, output int t);
    req.valid = 1'b1;
    req.write = wr;
    req.wstrb = st;
    req.addr  = a;
    req.wdata = wd;
    t = edge_n + 1;
    @(posedge clk);
    #1;
    req.valid = 1'b0;
    req.wdata = $urandom;
    req.addr  = $urandom;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic check_txn(input string nm, input int t, input logic e_er,
                           input logic [31:0] e_rd, input bit has_pulse, input logic [NR-1:0] pv);
    for (int i = 0; i < NI; i++) begin
      string p;
      p = $sformatf("%s_w%0d", nm, wv(i));
      check({p, "_nrsp"}, rq[i].size() - bq[i], 1);
      if (rq[i].size() > bq[i]) begin
        check({p, "_lat"}, rq[i][bq[i]].e - t + 1, lit_lat(i));
        check({p, "_err"}, rq[i][bq[i]].err, e_er);
        check({p, "_rdata"}, rq[i][bq[i]].rd, e_rd);
      end
      check({p, "_npulse"}, pq[i].size() - bp[i], has_pulse ? 1 : 0);
      if (has_pulse && pq[i].size() > bp[i] && rq[i].size() > bq[i]) begin
        check({p, "_pval"}, pq[i][bp[i]].v, pv);
        check({p, "_pwhen"}, pq[i][bp[i]].e - rq[i][bq[i]].e, 1);
      end
    end
  endtask

  initial begin
    int t;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_regs", regs_v[0], '0);
    check("rst_rsp", rsp[0], '0);
    check("rst_busy", busy_v[0], 1'b0);
    check("rst_pulse", pl[0], '0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset during the wait of a write to 0x4 must abort it
    snap();
    req.valid = 1'b1; req.write = 1'b1; req.wstrb = 4'hF;
    req.addr  = 32'h4; req.wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    req.valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      if (wv(i) > 0) check($sformatf("rstmid_w%0d_nrsp", wv(i)), rq[i].size() - bq[i], 0);
      check($sformatf("rstmid_w%0d_regs", wv(i)), regs_v[i], '0);
      check($sformatf("rstmid_w%0d_busy", wv(i)), busy_v[i], 1'b0);
      check($sformatf("rstmid_w%0d_npulse", wv(i)), pq[i].size() - bp[i], 0);
    end

    snap(); txn(1'b1, 4'hF, 32'h8, 32'hDEAD_BEEF, t);
    check_txn("wr8", t, 1'b0, 32'h0, 1'b1, 8'b0000_0100);
    check("wr8_reg2", regs_v[0][95:64], 32'hDEAD_BEEF);

    snap(); txn(1'b0, 4'h0, 32'h8, 32'h0, t);
    check_txn("rd8", t, 1'b0, 32'hDEAD_BEEF, 1'b0, '0);

    snap(); txn(1'b1, 4'b0101, 32'h8, 32'h1122_3344, t);
    check_txn("strb", t, 1'b0, 32'h0, 1'b1, 8'b0000_0100);
    check("strb_reg2", regs_v[0][95:64], 32'hDE22_BE44);

    snap(); txn(1'b1, 4'h0, 32'hC, 32'hFFFF_FFFF, t);
    check_txn("strb0", t, 1'b0, 32'h0, 1'b1, 8'b0000_1000);

    snap(); txn(1'b1, 4'hF, 32'h20, 32'hCAFE_F00D, t);
    check_txn("err_oor", t, 1'b1, 32'h0, 1'b0, '0);

    snap(); txn(1'b0, 4'h0, 32'h6, 32'h0, t);
    check_txn("err_mis", t, 1'b1, 32'h0, 1'b0, '0);
    for (int i = 0; i < NI; i++)
      check($sformatf("err_regs_w%0d", wv(i)), regs_v[i], {160'h0, 32'hDE22_BE44, 64'h0});

    // Valid held high: each instance restarts right after its RESP
    snap();
    req.valid = 1'b1; req.write = 1'b0; req.addr = 32'h8;
    repeat (36) @(posedge clk);
    #1;
    req.valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("b2b_w%0d_two", wv(i)), rq[i].size() - bq[i] >= 2, 1'b1);
      if (rq[i].size() - bq[i] >= 2)
        check($sformatf("b2b_w%0d_gap", wv(i)), rq[i][bq[i]+1].e - rq[i][bq[i]].e, lit_gap(i));
    end

    // Random traffic with occasional resets and abusive valid patterns
    for (int c = 0; c < 1500; c++) begin
      int idx;
      rst        = ($urandom_range(0, 299) == 0);
      req.valid  = ($urandom_range(0, 3) != 0);
      req.write  = $urandom_range(0, 1) != 0;
      req.wstrb  = 4'($urandom_range(0, 15));
      req.wdata  = $urandom;
      idx        = $urandom_range(0, 9);
      req.addr   = 32'(idx * 4 + (($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0));
      if ($urandom_range(0, 15) == 0) req.addr = $urandom;
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    req.valid = 1'b0;
    repeat (25) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/im2col_spc_regintfc_responder.md
Name: im2col_spc_regintfc_responder

Overview:
Register-interface (reg_pkg) target that answers reg_req_t transactions from an initiator (e.g. the im2col SPC AOPB master port) with reg_rsp_t responses. It holds a bank of NUM_REGS 32-bit software-visible registers with byte-strobe writes. It returns read data after a programmable number of wait cycles and flags misaligned or out-of-range accesses as errors. Register contents and per-register write pulses are exported to downstream accelerator logic.

Parameters:
NUM_REGS, 8, number of 32-bit registers; valid range 1..64
WAIT_CYCLES, 1, extra cycles between request acceptance and ready; valid range 0..15

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
reg_req_i  input  reg_req_t  request: valid, write, wstrb[3:0], addr[31:0], wdata[31:0]
reg_rsp_o  output  reg_rsp_t  response: ready, error, rdata[31:0]
regs_o  output  NUM_REGS*32  flattened register contents; reg k at bits [32k+31:32k]
wr_pulse_o  output  NUM_REGS  one-cycle pulse per register updated by a write
busy_o  output  1  high while a transaction is in progress (any state other than IDLE)

Behaviour:
- Reset, sampled on posedge clk_i while rst_i=1:
  - all registers 0; reg_rsp_o.ready=0, .error=0, .rdata=0; wr_pulse_o=0; state IDLE.
  - Reset mid-transaction aborts it, no write is applied, and no ready is issued.
- Address decode: idx = addr[31:2].
  - Error if addr[1:0]!=0 or idx>=NUM_REGS.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If reg_req_i.valid=1, latch write, wstrb, addr, wdata and the computed error flag.
  - Go to WAIT if WAIT_CYCLES>0, else to RESP.
  - Wait counter loads WAIT_CYCLES-1.
- WAIT:
  - Counter decrements each cycle; at 0 go to RESP.
  - Changes on reg_req_i in this state are ignored because the latched copy is used.
- RESP, exactly one cycle:
  - ready=1 and error=latched error.
  - Read without error: rdata = current contents of reg[idx].
  - Write, or any error: rdata=0.
  - Next state is IDLE unconditionally, including when the initiator has dropped valid.
- Latency: request sampled at edge T in IDLE → ready high during cycle T+1+WAIT_CYCLES. With WAIT_CYCLES=0, ready is high in the cycle after acceptance.
- Throughput: at most one transaction per 2+WAIT_CYCLES cycles. A request still held valid in the cycle after RESP is treated as a new transaction. Initiators must drop valid in the cycle ready is seen.
- ready, error and rdata are registered outputs, driven only in RESP and otherwise 0.
- Writes:
  - Applied at the clock edge ending the RESP cycle, only if there is no error.
  - Byte b of reg[idx] is updated iff wstrb[b]=1.
  - wstrb=0 performs no update but still produces wr_pulse_o[idx]=1 and a non-error response.
  - New regs_o value and wr_pulse_o[idx]=1 are visible together in the cycle after RESP.
  - wr_pulse_o is 0 in all other cycles.
- Errors never modify any register and never pulse wr_pulse_o.
- busy_o=1 in WAIT and RESP, 0 in IDLE.

Test Plan:
- Reset: drive rst_i=1 for 2 cycles mid-WAIT of a write to addr 0x4 → no ready, regs_o all 0, busy_o=0, wr_pulse_o=0.
- Write then read (WAIT_CYCLES=1): write addr 0x8, wdata 0xDEADBEEF, wstrb 4'b1111 → ready exactly 2 cycles after acceptance, error=0, then wr_pulse_o=8'b0000_0100 for 1 cycle and regs_o reg2=0xDEADBEEF. Read addr 0x8 → rdata=0xDEADBEEF.
- Byte strobes: reg2=0xDEADBEEF, write 0x11223344 with wstrb 4'b0101 → reg2=0xDE22BE44.
- Errors: write addr 0x20 with NUM_REGS=8 → error=1, rdata=0, no wr_pulse. Read addr 0x6 (misaligned) → error=1, rdata=0. All registers unchanged.
- Latency sweep: WAIT_CYCLES ∈ {0,3,15} → ready at T+1, T+4, T+16 respectively, each for exactly 1 cycle.
- Back-to-back and protocol abuse:
  - Valid held high continuously across two reads → second ready arrives 2+WAIT_CYCLES cycles after the first.
  - Valid dropped during WAIT → RESP still occurs once, then IDLE.
